// File: rtl/sao_pkg.sv
// sao_pkg: shared FSM states and SAO/LCU code points for the SAO control path.
package sao_pkg;
    typedef enum logic [1:0] {ST_LOAD, ST_PROC, ST_DRAIN, ST_DONE} state_t;
    typedef enum logic [1:0] {SZ_16, SZ_32, SZ_64, SZ_RSVD} lcu_size_t;
    typedef enum logic [1:0] {TYPE_OFF, TYPE_BO, TYPE_EO, TYPE_RSVD} sao_type_t;
    typedef enum logic {EO_HOR, EO_VER} eo_class_t;
    function automatic lcu_size_t norm_size(input logic [1:0] s);
        return s == 2'd3 ? SZ_16 : lcu_size_t'(s);
    endfunction
    function automatic sao_type_t norm_type(input logic [1:0] t);
        return t == 2'd3 ? TYPE_OFF : sao_type_t'(t);
    endfunction
endpackage

// File: rtl/sao_lcu_addr_gen.sv
// sao_lcu_addr_gen: raster x/y walker over one NxN LCU with buffer index, SRAM address and edge flags.
module sao_lcu_addr_gen
    import sao_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  lcu_size_t         size,
    input  logic [2:0]        lcu_x,
    input  logic [2:0]        lcu_y,
    output logic [11:0]       idx,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              x_edge,
    output logic              y_edge,
    output logic              last
);
    int n;
    logic [5:0] x, y, nm1;
    assign n = 16 << size;
    assign nm1 = 6'(n - 1);
    assign idx = 12'(int'(y) * n + int'(x));
    assign sram_addr = ADDR_W'((int'(lcu_y) * n + int'(y)) * IMG_W + int'(lcu_x) * n + int'(x));
    assign x_edge = x == '0 || x == nm1;
    assign y_edge = y == '0 || y == nm1;
    assign last = x == nm1 && y == nm1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            x <= x == nm1 ? '0 : x + 1'b1;
            y <= x == nm1 ? (y == nm1 ? '0 : y + 1'b1) : y;
        end
    end
endmodule

// File: rtl/sao_lcu_ctrl.sv
// sao_lcu_ctrl: loads one LCU of raster pixels, replays it through the offset pipe
// and issues the PIPE-delayed write-back address of every pixel into the result SRAM.
module sao_lcu_ctrl
    import sao_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIPE   = 2,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [2:0]        lcu_x,
    input  logic [2:0]        lcu_y,
    input  logic [1:0]        lcu_size,
    input  logic [1:0]        sao_type,
    input  logic              sao_eo_class,
    output logic              busy,
    output logic              finish,
    output logic              buf_wen,
    output logic [11:0]       buf_waddr,
    output logic [11:0]       buf_raddr,
    output logic              proc_en,
    output logic              proc_bypass,
    output logic [1:0]        proc_type,
    output logic              proc_eo_class,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr
);
    state_t state;
    lcu_size_t cfg_size;
    sao_type_t cfg_type;
    eo_class_t cfg_eo;
    logic [2:0] cfg_x, cfg_y;
    logic [3:0] dcnt;
    logic [11:0] idx;
    logic [ADDR_W-1:0] gen_addr;
    logic x_edge, y_edge, last, accept, last_lcu;
    logic [PIPE-1:0] pv;
    logic [ADDR_W-1:0] pa [PIPE];
    assign accept = in_en & ~busy;
    assign buf_wen = accept;
    assign buf_waddr = state == ST_LOAD ? idx : '0;
    assign buf_raddr = state == ST_PROC ? idx : '0;
    assign proc_en = state == ST_PROC;
    assign proc_type = cfg_type;
    assign proc_eo_class = cfg_eo;
    assign proc_bypass = proc_en && (cfg_type == TYPE_OFF ||
                         (cfg_type == TYPE_EO && (cfg_eo == EO_VER ? y_edge : x_edge)));
    assign last_lcu = cfg_x == 3'((IMG_W >> (4 + int'(cfg_size))) - 1) &&
                      cfg_y == 3'((IMG_H >> (4 + int'(cfg_size))) - 1);
    assign sram_wen = pv[PIPE-1];
    assign sram_addr = pa[PIPE-1];
    sao_lcu_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr (
        .clk       (clk),
        .reset     (reset),
        .adv       ((state == ST_LOAD && accept) || state == ST_PROC),
        .size      (cfg_size),
        .lcu_x     (cfg_x),
        .lcu_y     (cfg_y),
        .idx       (idx),
        .sram_addr (gen_addr),
        .x_edge    (x_edge),
        .y_edge    (y_edge),
        .last      (last)
    );
    // Config is sampled only at count 0 so mid-LCU input changes never affect indexing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LOAD;
            busy     <= 1'b0;
            finish   <= 1'b0;
            dcnt     <= '0;
            cfg_x    <= '0;
            cfg_y    <= '0;
            cfg_size <= SZ_16;
            cfg_type <= TYPE_OFF;
            cfg_eo   <= EO_HOR;
        end else begin
            case (state)
                ST_LOAD: if (accept) begin
                    if (idx == '0) begin
                        cfg_x    <= lcu_x;
                        cfg_y    <= lcu_y;
                        cfg_size <= norm_size(lcu_size);
                        cfg_type <= norm_type(sao_type);
                        cfg_eo   <= eo_class_t'(sao_eo_class);
                    end
                    if (last) begin
                        busy  <= 1'b1;
                        state <= ST_PROC;
                    end
                end
                ST_PROC: if (last) begin
                    state <= ST_DRAIN;
                    dcnt  <= '0;
                end
                ST_DRAIN: if (dcnt == 4'(PIPE - 1)) begin
                    state  <= last_lcu ? ST_DONE : ST_LOAD;
                    busy   <= last_lcu;
                    finish <= last_lcu;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv <= '0;
            for (int i = 0; i < PIPE; i++) pa[i] <= '0;
        end else begin
            pv[0] <= proc_en;
            pa[0] <= proc_en ? gen_addr : '0;
            for (int i = 1; i < PIPE; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end
endmodule
